// File: rtl/float_unit_arbiter.sv
// float_unit_arbiter
//
// Round-robin arbiter and sequencer that shares one float register + increment unit between
// NUM_REQ requesters. One operand is accepted at a time, written into the shared unit, and the
// unit's +1 result is returned with the requester ID on a valid/ready response port. This block
// only moves bits; it never changes operand or result values.
//
// Optional feature (compile-time macro FLOAT_ARB_PERF_EN): adds the perf_ops_o and perf_stall_o
// counters. Without the macro those ports and counters do not exist.
//
// Ports:
//   clk_i         clock
//   rst_i         asynchronous, active-high reset
//   req_valid_i   per-requester operand valid
//   req_data_i    per-requester operand (packed array of float_t)
//   req_ready_o   one-hot accept, only in idle
//   unit_wen_o    write enable to the shared unit (one cycle per operation)
//   unit_wdata_o  operand written to the shared unit
//   unit_plus1_i  operand+1 returned by the shared unit
//   resp_valid_o  result valid
//   resp_ready_i  result accepted by the consumer
//   resp_id_o     requester ID belonging to the result
//   resp_data_o   operand+1 result
//   busy_o        high whenever an operation is in flight
//   perf_ops_o    (FLOAT_ARB_PERF_EN) completed response handshakes
//   perf_stall_o  (FLOAT_ARB_PERF_EN) cycles with a response held by backpressure

package float_pkg;
  typedef logic [31:0] float_t;
endpackage

module float_unit_arbiter
  import float_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdWidth = $clog2(NUM_REQ)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic   [NUM_REQ-1:0]       req_valid_i,
  input  float_t [NUM_REQ-1:0]       req_data_i,
  output logic   [NUM_REQ-1:0]       req_ready_o,
  output logic                       unit_wen_o,
  output float_t                     unit_wdata_o,
  input  float_t                     unit_plus1_i,
  output logic                       resp_valid_o,
  input  logic                       resp_ready_i,
  output logic   [IdWidth-1:0]       resp_id_o,
  output float_t                     resp_data_o,
  output logic                       busy_o
`ifdef FLOAT_ARB_PERF_EN
  ,
  output logic   [31:0]              perf_ops_o,
  output logic   [31:0]              perf_stall_o
`endif
);

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StResp} state_e;

  state_e               state_q, state_d;
  logic [IdWidth-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdWidth-1:0]   id_q, id_d;
  float_t               op_q, op_d;
  float_t               resp_data_q, resp_data_d;

  logic                 grant_found;
  logic [IdWidth-1:0]   grant_id;

  // First valid requester at or after rr_ptr_q, wrapping around.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (!grant_found && req_valid_i[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx[IdWidth-1:0];
      end
    end
  end

  // Ready is combinational from valid; masked during reset so outputs read zero.
  always_comb begin
    req_ready_o = '0;
    if (state_q == StIdle && grant_found && !rst_i) begin
      req_ready_o = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    op_d         = op_q;
    resp_data_d  = resp_data_q;
    unit_wen_o   = 1'b0;
    resp_valid_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          op_d    = req_data_i[grant_id];
          id_d    = grant_id;
          state_d = StLoad;
          if (grant_id == IdWidth'(NUM_REQ - 1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = grant_id + 1'b1;
          end
        end
      end
      StLoad: begin
        unit_wen_o = 1'b1;
        state_d    = StWait;
      end
      StWait: begin
        // Unit register was written at the end of StLoad, so its +1 output is valid now.
        resp_data_d = unit_plus1_i;
        state_d     = StResp;
      end
      StResp: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      op_q        <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      op_q        <= op_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign unit_wdata_o = op_q;
  assign resp_id_o    = id_q;
  assign resp_data_o  = resp_data_q;
  assign busy_o       = (state_q != StIdle);

`ifdef FLOAT_ARB_PERF_EN
  logic [31:0] perf_ops_q, perf_ops_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_ops_d   = perf_ops_q;
    perf_stall_d = perf_stall_q;
    if (state_q == StResp) begin
      if (resp_ready_i) begin
        perf_ops_d = perf_ops_q + 32'd1;
      end else begin
        perf_stall_d = perf_stall_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_ops_q   <= perf_ops_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_ops_o   = perf_ops_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule
